// File: rtl/excess3_to_bcd_serial_pkg.sv
// Shared constants and types for the serial Excess-3 decoder.
// No backpressure; pure definitions.
package e3_pkg;
    localparam logic [3:0] E3_OFFSET = 4'd3;
    localparam logic [3:0] E3_MIN    = 4'd3;
    localparam logic [3:0] E3_MAX    = 4'd12;
    localparam int         DIGIT_W   = 4;

    typedef logic [1:0] bit_cnt_t;

    function automatic logic e3_code_valid(input logic [DIGIT_W-1:0] code);
        return (code >= E3_MIN) && (code <= E3_MAX);
    endfunction
endpackage

// File: rtl/excess3_to_bcd_serial_if.sv
// Serial bit stream in, BCD stream plus digit/word flags out; zero-latency s, registered flags.
// No backpressure: the producer strobes bits with x_valid and the decoder always accepts.
interface excess3_to_bcd_serial_if
    import e3_pkg::*;
#(
    parameter int NDIGITS = 4
);
    logic                       start;
    logic                       x_valid;
    logic                       x;
    logic                       s;
    logic                       s_valid;
    logic                       digit_done;
    logic                       digit_err;
    logic                       busy;
    logic [DIGIT_W*NDIGITS-1:0] bcd_word;
    logic                       word_valid;

    modport master (
        output start, x_valid, x,
        input  s, s_valid, digit_done, digit_err, busy, bcd_word, word_valid
    );

    modport slave (
        input  start, x_valid, x,
        output s, s_valid, digit_done, digit_err, busy, bcd_word, word_valid
    );
endinterface

// File: rtl/e3_serial_sub.sv
// One-bit serial subtractor of the Excess-3 offset; s is combinational, borrow updates on strobed falling edges.
// No backpressure: holds its borrow whenever i_en is low.
module e3_serial_sub
    import e3_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     i_en,
    input  logic     i_x,
    input  bit_cnt_t i_bit_cnt,
    output logic     o_s
);
    logic r_borrow;
    logic w_sub;
    logic w_borrow_in;
    logic w_borrow_next;

    // Bit 0 ignores the stored borrow so every digit subtracts independently.
    assign w_sub         = E3_OFFSET[i_bit_cnt];
    assign w_borrow_in   = (i_bit_cnt == 2'd0) ? 1'b0 : r_borrow;
    assign o_s           = i_x ^ w_sub ^ w_borrow_in;
    assign w_borrow_next = (~i_x & w_sub) | (~i_x & w_borrow_in) | (w_sub & w_borrow_in);

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_borrow <= 1'b0;
        end else if (i_en) begin
            r_borrow <= w_borrow_next;
        end
    end
endmodule

// File: rtl/excess3_to_bcd_serial.sv
// Bit-serial Excess-3 to BCD decoder; s is same-cycle (Mealy), digit/word flags one falling edge later.
// No backpressure: every strobed bit is consumed; E3D_WORD_OUT_EN adds the parallel bcd_word output.
module excess3_to_bcd_serial
    import e3_pkg::*;
#(
    parameter int NDIGITS = 4
)(
    input  logic                      clk,
    input  logic                      rst_n,
    excess3_to_bcd_serial_if.slave    bus
);
    localparam int             DCW        = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [DCW-1:0] LAST_DIGIT = DCW'(NDIGITS - 1);

    bit_cnt_t             r_bit_cnt;
    logic [DCW-1:0]       r_digit_cnt;
    logic [DIGIT_W-1:0]   r_code;
    logic                 r_digit_done;

    bit_cnt_t             w_bit_cnt;
    logic [DCW-1:0]       w_digit_cnt;
    logic                 w_s;
    logic                 w_complete;

    // start realigns the frame for the current cycle, which also suppresses any completion.
    assign w_bit_cnt   = bus.start ? 2'd0 : r_bit_cnt;
    assign w_digit_cnt = bus.start ? '0 : r_digit_cnt;
    assign w_complete  = bus.x_valid && (w_bit_cnt == 2'd3);

    e3_serial_sub u_sub (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_en      (bus.x_valid),
        .i_x       (bus.x),
        .i_bit_cnt (w_bit_cnt),
        .o_s       (w_s)
    );

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt    <= 2'd0;
            r_digit_cnt  <= '0;
            r_code       <= '0;
            r_digit_done <= 1'b0;
        end else begin
            r_digit_done <= w_complete;
            if (bus.x_valid) begin
                r_bit_cnt <= w_bit_cnt + 2'd1;
                r_code    <= {bus.x, r_code[DIGIT_W-1:1]};
            end else begin
                r_bit_cnt <= w_bit_cnt;
            end
            if (w_complete) begin
                r_digit_cnt <= (w_digit_cnt == LAST_DIGIT) ? '0 : w_digit_cnt + DCW'(1);
            end else begin
                r_digit_cnt <= w_digit_cnt;
            end
        end
    end

    assign bus.s          = w_s;
    assign bus.s_valid    = bus.x_valid;
    assign bus.digit_done = r_digit_done;
    // r_code holds the just-finished code for exactly the pulse cycle.
    assign bus.digit_err  = r_digit_done & ~e3_code_valid(r_code);
    assign bus.busy       = (r_bit_cnt != 2'd0) || (r_digit_cnt != '0);

`ifdef E3D_WORD_OUT_EN
    logic [DIGIT_W-2:0]         r_bcd_sr;
    logic [DIGIT_W*NDIGITS-1:0] r_stage;
    logic [DIGIT_W*NDIGITS-1:0] r_word;
    logic                       r_word_vld;
    logic [DIGIT_W-1:0]         w_nibble;
    logic [DIGIT_W*NDIGITS-1:0] w_stage_next;

    // The top BCD bit is taken live from s, so only three earlier bits need storage.
    assign w_nibble = {w_s, r_bcd_sr};

    always_comb begin
        w_stage_next = r_stage;
        for (int i = 0; i < NDIGITS; i++) begin
            if (w_digit_cnt == DCW'(i)) begin
                w_stage_next[i*DIGIT_W +: DIGIT_W] = w_nibble;
            end
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bcd_sr   <= '0;
            r_stage    <= '0;
            r_word     <= '0;
            r_word_vld <= 1'b0;
        end else begin
            r_word_vld <= w_complete && (w_digit_cnt == LAST_DIGIT);
            if (bus.x_valid) begin
                r_bcd_sr <= {w_s, r_bcd_sr[DIGIT_W-2:1]};
            end
            if (w_complete) begin
                r_stage <= w_stage_next;
                if (w_digit_cnt == LAST_DIGIT) begin
                    r_word <= w_stage_next;
                end
            end
        end
    end

    assign bus.bcd_word   = r_word;
    assign bus.word_valid = r_word_vld;
`else
    assign bus.bcd_word   = '0;
    assign bus.word_valid = 1'b0;
`endif
endmodule

// File: tb/tb_excess3_to_bcd_serial.sv
// Bench for excess3_to_bcd_serial: directed digits, expectations queued at issue, popped by a monitor.
// Inputs change just after the falling (active) edge; outputs are sampled on the rising edge.
module tb_excess3_to_bcd_serial;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    excess3_to_bcd_serial_if #(.NDIGITS(4)) bus();

    excess3_to_bcd_serial #(.NDIGITS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    logic        exp_s_q[$];
    logic        exp_err_q[$];
    logic [15:0] exp_word_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    task automatic fail_extra(input string name, input logic [31:0] act);
        n_total++;
        $display("FAIL %s: got %0h with no expectation queued, required no event", name, act);
    endtask

    // Monitor: pops an expectation whenever the DUT presents an output event.
    always @(posedge clk) begin
        if (bus.s_valid) begin
            if (exp_s_q.size() == 0) fail_extra("s_extra", 32'(bus.s));
            else check("s", 32'(bus.s), 32'(exp_s_q.pop_front()));
        end
        if (bus.digit_done) begin
            if (exp_err_q.size() == 0) fail_extra("digit_done_extra", 32'(bus.digit_err));
            else check("digit_err", 32'(bus.digit_err), 32'(exp_err_q.pop_front()));
        end else if (bus.digit_err) begin
            fail_extra("digit_err_stray", 32'(bus.digit_err));
        end
        if (bus.word_valid) begin
            if (exp_word_q.size() == 0) fail_extra("word_valid_extra", 32'(bus.bcd_word));
            else check("bcd_word", 32'(bus.bcd_word), 32'(exp_word_q.pop_front()));
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk); #1;
            bus.x_valid = 1'b0;
            bus.start   = 1'b0;
            bus.x       = 1'b0;
        end
    endtask

    task automatic send_bit(input logic b, input logic st, input logic exp_s);
        @(negedge clk); #1;
        bus.start   = st;
        bus.x       = b;
        bus.x_valid = 1'b1;
        exp_s_q.push_back(exp_s);
    endtask

    task automatic send_digit(input logic [3:0] code, input logic [3:0] bcd,
                              input logic err, input logic st, input int gap);
        for (int i = 0; i < 4; i++) begin
            send_bit(code[i], st && (i == 0), bcd[i]);
            if (gap > 0 && i < 3) idle(gap);
        end
        exp_err_q.push_back(err);
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.x_valid = 1'b0;
        bus.x       = 1'b0;
        rst_n       = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_digit_done", 32'(bus.digit_done), 32'd0);
        check("rst_digit_err",  32'(bus.digit_err),  32'd0);
        check("rst_busy",       32'(bus.busy),       32'd0);
        check("rst_bcd_word",   32'(bus.bcd_word),   32'd0);
        check("rst_word_valid", 32'(bus.word_valid), 32'd0);
        rst_n = 1'b1;

        // Frame 1: 8->5, 3->0, 12->9, then 8->5 with 3-cycle gaps between bits.
`ifdef E3D_WORD_OUT_EN
        exp_word_q.push_back(16'h5905);
`endif
        send_digit(4'b1000, 4'd5, 1'b0, 1'b1, 0);
        send_digit(4'b0011, 4'd0, 1'b0, 1'b0, 0);
        send_digit(4'b1100, 4'd9, 1'b0, 1'b0, 0);
        send_digit(4'b1000, 4'd5, 1'b0, 1'b0, 3);
        idle(2);
        check("busy_after_frame1", 32'(bus.busy), 32'd0);

        // Frame 2: all invalid codes, raw modulo-16 differences.
`ifdef E3D_WORD_OUT_EN
        exp_word_q.push_back(16'hCAFD);
`endif
        send_digit(4'b0000, 4'hD, 1'b1, 1'b1, 0);
        send_digit(4'b0010, 4'hF, 1'b1, 1'b0, 0);
        send_digit(4'b1101, 4'hA, 1'b1, 1'b0, 0);
        send_digit(4'b1111, 4'hC, 1'b1, 1'b0, 0);
        idle(2);

        // Frame 3: digits 1,2,3,4.
`ifdef E3D_WORD_OUT_EN
        exp_word_q.push_back(16'h4321);
`endif
        send_digit(4'b0100, 4'd1, 1'b0, 1'b1, 0);
        send_digit(4'b0101, 4'd2, 1'b0, 1'b0, 0);
        send_digit(4'b0110, 4'd3, 1'b0, 1'b0, 0);
        send_digit(4'b0111, 4'd4, 1'b0, 1'b0, 0);
        idle(2);
        check("busy_after_frame3", 32'(bus.busy), 32'd0);
`ifdef E3D_WORD_OUT_EN
        check("bcd_word_hold", 32'(bus.bcd_word), 32'h4321);
`else
        check("bcd_word_tied", 32'(bus.bcd_word), 32'h0);
`endif

        // Two bits of a digit, then start restarts with a full 8->5.
        send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b0, 1'b0, 1'b1);
        send_digit(4'b1000, 4'd5, 1'b0, 1'b1, 0);
        idle(1);
        check("busy_digit_cnt1", 32'(bus.busy), 32'd1);

        // Two bits of digit 1, then asynchronous reset between edges.
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        idle(1);
        @(posedge clk); #2;
        check("busy_mid_digit", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_busy",       32'(bus.busy),       32'd0);
        check("async_rst_digit_done", 32'(bus.digit_done), 32'd0);
        check("async_rst_bcd_word",   32'(bus.bcd_word),   32'd0);
        check("async_rst_word_valid", 32'(bus.word_valid), 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        send_digit(4'b1000, 4'd5, 1'b0, 1'b0, 0);
        idle(3);
        check("busy_after_rst_digit", 32'(bus.busy), 32'd1);

        check("s_queue_left",    32'(exp_s_q.size()),    32'd0);
        check("err_queue_left",  32'(exp_err_q.size()),  32'd0);
        check("word_queue_left", 32'(exp_word_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/excess3_to_bcd_serial.md
Name: excess3_to_bcd_serial

Overview:
Bit-serial Excess-3 to BCD decoder. It is the receive-side counterpart of the team's serial BCD-to-Excess-3 encoder. It accepts 4-bit Excess-3 digits LSB-first, one bit per strobed cycle, and emits the BCD bit stream in the same cycle (Mealy output). It also flags invalid codes per digit and, optionally, assembles an NDIGITS-wide parallel BCD word for downstream display and arithmetic blocks.

Parameters:
NDIGITS, 4, digits per frame; sets the digit counter range and the bcd_word width.

Ports:
clk  input  1  system clock; all state updates on the falling edge
rst_n  input  1  asynchronous active-low reset
start  input  1  frame alignment; current bit becomes bit 0 of digit 0
x_valid  input  1  bit strobe; x is consumed only when high
x  input  1  serial Excess-3 bit, LSB first
s  output  1  serial BCD bit, combinational from x and state
s_valid  output  1  equals x_valid, combinational
digit_done  output  1  registered one-cycle pulse after the 4th bit of a digit is consumed
digit_err  output  1  registered; qualifies digit_done; the digit's code was outside 3..12
busy  output  1  high while a frame is partially received
bcd_word  output  4*NDIGITS  assembled BCD word; digit 0 sits at bits [3:0]
word_valid  output  1  registered one-cycle pulse when bcd_word updates

Behaviour:
- Reset (rst_n low, asynchronous): bit_cnt=0, digit_cnt=0, borrow=0, code shift register=0, digit_done=0, digit_err=0, busy=0, bcd_word=0, word_valid=0.
- Reset mid-digit discards the partial digit; there is no output for it.
- Serial subtraction of 0011:
  - The subtrahend bit is 1 at bit_cnt 0 and 1, and 0 at bit_cnt 2 and 3.
  - s = x ^ sub ^ borrow.
  - borrow_next = (~x & sub) | (~x & borrow) | (sub & borrow).
  - Borrow clears at bit_cnt 0, so each digit is independent.
  - s is don't-care when x_valid is low; the bench must not check it then.
- bit_cnt advances 0→1→2→3→0 on each falling edge with x_valid=1. With x_valid=0, all state holds: gaps of any length are legal.
- Each consumed x is shifted into a 4-bit code register. Each s is shifted into a 4-bit BCD digit register.
- At bit_cnt=3 with x_valid=1, on the following edge:
  - digit_done=1.
  - digit_err=1 if the full code is in {0,1,2,13,14,15}.
  - digit_cnt increments, wrapping to 0 after NDIGITS-1.
- On an error digit the BCD bits are still emitted, as the raw modulo-16 difference.
- busy=1 when bit_cnt≠0 or digit_cnt≠0.
- start=1:
  - bit_cnt, digit_cnt and borrow are treated as 0 for the current cycle.
  - If x_valid=1 in the same cycle, x is consumed as bit 0 of digit 0.
  - start mid-digit abandons that digit with no digit_done.
- start and digit completion in the same cycle: start wins, and no digit_done is generated.
- digit_done and digit_err are low in every cycle except the pulse cycle.

Optional Feature:
Macro E3D_WORD_OUT_EN.
- Defined:
  - Each completed digit's BCD nibble is written into a staging word at slot digit_cnt.
  - When digit NDIGITS-1 completes, bcd_word loads the staging word and word_valid pulses in the same cycle as that digit_done.
  - bcd_word holds until the next full word.
  - An error in any digit of the frame does not block the load; the per-digit digit_err is the indication.
- Undefined: bcd_word is tied to 0, word_valid is tied to 0, and no staging storage is inferred.

Decomposition:
- Shared package e3_pkg holds:
  - E3_OFFSET = 4'd3.
  - Valid-code bounds E3_MIN = 4'd3 and E3_MAX = 4'd12.
  - DIGIT_W = 4.
  - The bit_cnt typedef (2 bits).
- One natural sub-module, e3_serial_sub: the 1-bit borrow subtractor, holding the borrow flop and the combinational s. The top module keeps the counters, validity check and word assembly.

Test Plan:
- Reset, then start with bits 0,0,0,1 (code 1000) → s=1,0,1,0 (BCD 5); digit_done=1 with digit_err=0 on the edge after the 4th bit.
- Codes 0011 and 1100 → s gives BCD 0 and 9; digit_err=0. Codes 0000, 0010, 1101, 1111 → digit_err=1 each.
- Digit 1000 sent with x_valid low for 3 cycles between each bit → identical s sequence and a single digit_done.
- E3D_WORD_OUT_EN defined, NDIGITS=4: codes 0100, 0101, 0110, 0111 (digits 1,2,3,4) → bcd_word=16'h4321, word_valid pulses once, aligned with the last digit_done.
- start asserted after 2 bits of a digit, then a full 1000 → no digit_done for the partial digit; s=1,0,1,0; digit_cnt=1 afterward.
- rst_n dropped asynchronously mid-digit between edges → outputs 0 immediately; the next digit decodes correctly from bit 0.
